decode_queue_unit: RTL and testbench
====================================

// Module: decode_queue_unit
// PURPOSE
//  Buffered, parametrised successor to the combinational control unit. Accepts fetched instructions
//  with their PC over a valid/ready handshake and holds them in a DEPTH-entry queue. It decodes the
//  queue head into a packed control bundle and presents it to the execute side over a second
//  valid/ready handshake. Adds flush, sticky halt and LL/SC atomic decode. It sits between fetch and execute.
// PARAMETERS
//  DEPTH   4   queue entries; power of 2, >= 2
//  WORD_W  32  instruction and PC width
// PORTS
//  CLK          in   1         clock; one clock domain, all state updates on the rising edge
//  RST          in   1         reset; synchronous and active-high
//  flush        in   1         discard every queued entry (branch/jump redirect)
//  instr_valid  in   1         fetch side presents instr/pc
//  instr        in   WORD_W    raw instruction
//  pc_in        in   WORD_W    PC of instr
//  instr_ready  out  1         queue can accept an entry
//  ctrl_valid   out  1         ctrl/pc_out is valid
//  ctrl_ready   in   1         execute side consumes the head
//  ctrl         out  ctrl_t    decoded bundle of the head (see STRUCTURE)
//  pc_out       out  WORD_W    PC of the head
//  count        out  $clog2(DEPTH)+1  number of occupied entries
//  halted       out  1         sticky; a HALT has been consumed
// BEHAVIOUR
//  Reset (RST=1 at an edge): count=0, halted=0, read/write pointers=0.
//   While reset holds: ctrl_valid=0 and instr_ready=0. Reset mid-operation drops all entries.
//  Push: instr_valid && instr_ready at an edge. The entry is written at wptr and wptr advances.
//   Pointers are log2(DEPTH) bits and wrap naturally.
//  Pop: ctrl_valid && ctrl_ready at an edge. rptr advances.
//  instr_ready = !RST && !halted && (count < DEPTH). No push on full, even if a pop occurs in the same cycle.
//  ctrl_valid  = !RST && !halted && (count != 0).
//   ctrl and pc_out are combinational from the head entry. When ctrl_valid=0, ctrl is all-zero.
//  Latency: an entry pushed at edge N is visible on ctrl_valid after edge N (one cycle).
//  Simultaneous push and pop with 0 < count < DEPTH: count is unchanged, and both pointers advance.
//  Flush has priority: at the edge count<=0 and rptr<=wptr. A push or pop in the same cycle is ignored.
//   halted is unaffected by flush.
//  Halt: a pop of an entry with ctrl.halt=1 sets halted at that edge.
//   After that: count<=0, instr_ready=0 and ctrl_valid=0 until RST. A flush in the same cycle still sets halted.
//  Decode (head entry, opcode/funct from the cpu_types_pkg enums):
//   R-type: RegDst=1, RegWrite=1, ALUOp from funct. JR: JumpReg=1, RegWrite=0.
//   LW: MemRead=1, MemToReg=1, ALUSrc=1, SignExtend=1, RegWrite=1. SW: MemWrite=1, ALUSrc=1, SignExtend=1.
//   LL: as LW plus datomic=1. SC: MemWrite=1, RegWrite=1, MemToReg=1, datomic=1, ALUSrc=1, SignExtend=1.
//   BEQ: Branch=1, ALU SUB. BNE: Branch=1, BNE=1. J: Jump=1. JAL: Jump=1, JAL=1, RegWrite=1.
//   LUI: LUI=1, RegWrite=1. ANDI/ORI/XORI: zero-extended. ADDIU/SLTI/SLTIU: sign-extended.
//   HALT: halt=1 and every other field 0.
//   Any other opcode or funct: illegal=1 and every other field 0. It is still popped normally.
// STRUCTURE
//  cpu_types_pkg gains ctrl_t, a packed struct with fields
//   RegDst, Jump, JumpReg, JAL, Branch, BNE, MemRead, MemToReg, MemWrite, ALUSrc, RegWrite,
//   Halt, SignExtend, LUI, datomic, illegal, and ALUOp (aluop_t).
//  cpu_types_pkg also gains the constant CTRL_NOP = '0.
//  Sub-module instr_decoder: purely combinational, word_t in, ctrl_t out. It is instantiated once, on the head entry.
//  Queue storage is an array of {instr, pc}, plus rptr, wptr and count registers.
// TESTING
//  1 Reset, then push ADDU 0x00221821 with pc=0x0, ctrl_ready=0.
//    Next cycle: ctrl_valid=1, RegDst=1, RegWrite=1, ALUOp=ADD, pc_out=0x0, count=1.
//  2 Push 4 entries with ctrl_ready=0.
//    count=4, instr_ready=0, and a 5th push is ignored.
//    Then pop and push in the same cycle at count=3: count stays 3, order is preserved across pointer wrap.
//  3 Queue LW 0x8C220004, LL 0xC0220000, SC 0xE0220000.
//    LW: MemRead=1, datomic=0. LL: MemRead=1, datomic=1. SC: MemWrite=1, RegWrite=1, datomic=1.
//  4 With count=3, assert flush together with instr_valid.
//    Next cycle: count=0, ctrl_valid=0, and the new entry is not stored.
//  5 Queue HALT 0xFFFFFFFF, then ADDU, and pop HALT.
//    halted=1, ctrl_valid=0, instr_ready=0, count=0.
//    Further pushes are ignored. RST=1 for one cycle clears halted.
//  6 Push opcode 0x3F (not HALT, unknown).
//    ctrl.illegal=1, all other fields 0. Pop succeeds and halted stays 0.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: opcode/funct/ALU encodings and the decoded control bundle.
package cpu_types_pkg;

  localparam int WORD_BITS = 32;
  typedef logic [WORD_BITS-1:0] word_t;

  typedef enum logic [5:0] {
    OP_RTYPE = 6'h00,
    OP_J     = 6'h02,
    OP_JAL   = 6'h03,
    OP_BEQ   = 6'h04,
    OP_BNE   = 6'h05,
    OP_ADDIU = 6'h09,
    OP_SLTI  = 6'h0A,
    OP_SLTIU = 6'h0B,
    OP_ANDI  = 6'h0C,
    OP_ORI   = 6'h0D,
    OP_XORI  = 6'h0E,
    OP_LUI   = 6'h0F,
    OP_LW    = 6'h23,
    OP_SW    = 6'h2B,
    OP_LL    = 6'h30,
    OP_SC    = 6'h38,
    OP_HALT  = 6'h3F
  } opcode_t;

  typedef enum logic [5:0] {
    FN_SLL  = 6'h00,
    FN_SRL  = 6'h02,
    FN_JR   = 6'h08,
    FN_ADD  = 6'h20,
    FN_ADDU = 6'h21,
    FN_SUB  = 6'h22,
    FN_SUBU = 6'h23,
    FN_AND  = 6'h24,
    FN_OR   = 6'h25,
    FN_XOR  = 6'h26,
    FN_NOR  = 6'h27,
    FN_SLT  = 6'h2A,
    FN_SLTU = 6'h2B
  } funct_t;

  // SLL is encoding 0 so an all-zero bundle carries a zero ALUOp.
  typedef enum logic [3:0] {
    ALU_SLL  = 4'd0,
    ALU_SRL  = 4'd1,
    ALU_ADD  = 4'd2,
    ALU_SUB  = 4'd3,
    ALU_AND  = 4'd4,
    ALU_OR   = 4'd5,
    ALU_XOR  = 4'd6,
    ALU_NOR  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } aluop_t;

  typedef struct packed {
    logic   RegDst;
    logic   Jump;
    logic   JumpReg;
    logic   JAL;
    logic   Branch;
    logic   BNE;
    logic   MemRead;
    logic   MemToReg;
    logic   MemWrite;
    logic   ALUSrc;
    logic   RegWrite;
    logic   Halt;
    logic   SignExtend;
    logic   LUI;
    logic   datomic;
    logic   illegal;
    aluop_t ALUOp;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

  // The only legal HALT encoding is the all-ones word.
  localparam word_t HALT_WORD = '1;

endpackage

// File: rtl/instr_decoder.sv
// Combinational instruction decoder: raw word in, control bundle out.
module instr_decoder
  import cpu_types_pkg::*;
(
  input  word_t instr,
  output ctrl_t ctrl
);

  opcode_t op;
  funct_t  fn;
  assign op = opcode_t'(instr[31:26]);
  assign fn = funct_t'(instr[5:0]);

  // Opcode/funct to control fields; unknown encodings collapse to a bare illegal flag.
  always_comb begin
    ctrl = CTRL_NOP;
    case (op)
      OP_RTYPE: begin
        ctrl.RegDst   = 1'b1;
        ctrl.RegWrite = 1'b1;
        case (fn)
          FN_SLL:          ctrl.ALUOp = ALU_SLL;
          FN_SRL:          ctrl.ALUOp = ALU_SRL;
          FN_ADD, FN_ADDU: ctrl.ALUOp = ALU_ADD;
          FN_SUB, FN_SUBU: ctrl.ALUOp = ALU_SUB;
          FN_AND:          ctrl.ALUOp = ALU_AND;
          FN_OR:           ctrl.ALUOp = ALU_OR;
          FN_XOR:          ctrl.ALUOp = ALU_XOR;
          FN_NOR:          ctrl.ALUOp = ALU_NOR;
          FN_SLT:          ctrl.ALUOp = ALU_SLT;
          FN_SLTU:         ctrl.ALUOp = ALU_SLTU;
          FN_JR: begin
            ctrl         = CTRL_NOP;
            ctrl.JumpReg = 1'b1;
          end
          default: begin
            ctrl         = CTRL_NOP;
            ctrl.illegal = 1'b1;
          end
        endcase
      end
      OP_LW, OP_LL: begin
        ctrl.MemRead    = 1'b1;
        ctrl.MemToReg   = 1'b1;
        ctrl.ALUSrc     = 1'b1;
        ctrl.SignExtend = 1'b1;
        ctrl.RegWrite   = 1'b1;
        ctrl.ALUOp      = ALU_ADD;
        ctrl.datomic    = (op == OP_LL);
      end
      OP_SW: begin
        ctrl.MemWrite   = 1'b1;
        ctrl.ALUSrc     = 1'b1;
        ctrl.SignExtend = 1'b1;
        ctrl.ALUOp      = ALU_ADD;
      end
      // SC writes the success flag back through the memory-to-register path.
      OP_SC: begin
        ctrl.MemWrite   = 1'b1;
        ctrl.RegWrite   = 1'b1;
        ctrl.MemToReg   = 1'b1;
        ctrl.datomic    = 1'b1;
        ctrl.ALUSrc     = 1'b1;
        ctrl.SignExtend = 1'b1;
        ctrl.ALUOp      = ALU_ADD;
      end
      OP_BEQ: begin
        ctrl.Branch = 1'b1;
        ctrl.ALUOp  = ALU_SUB;
      end
      OP_BNE: begin
        ctrl.Branch = 1'b1;
        ctrl.BNE    = 1'b1;
        ctrl.ALUOp  = ALU_SUB;
      end
      OP_J: ctrl.Jump = 1'b1;
      OP_JAL: begin
        ctrl.Jump     = 1'b1;
        ctrl.JAL      = 1'b1;
        ctrl.RegWrite = 1'b1;
      end
      OP_LUI: begin
        ctrl.LUI      = 1'b1;
        ctrl.RegWrite = 1'b1;
        ctrl.ALUSrc   = 1'b1;
      end
      OP_ANDI, OP_ORI, OP_XORI: begin
        ctrl.ALUSrc   = 1'b1;
        ctrl.RegWrite = 1'b1;
        ctrl.ALUOp    = (op == OP_ANDI) ? ALU_AND : (op == OP_ORI) ? ALU_OR : ALU_XOR;
      end
      OP_ADDIU, OP_SLTI, OP_SLTIU: begin
        ctrl.ALUSrc     = 1'b1;
        ctrl.RegWrite   = 1'b1;
        ctrl.SignExtend = 1'b1;
        ctrl.ALUOp      = (op == OP_ADDIU) ? ALU_ADD : (op == OP_SLTI) ? ALU_SLT : ALU_SLTU;
      end
      // Opcode 0x3F alone is not enough; anything but the all-ones word is illegal.
      OP_HALT: begin
        if (instr == HALT_WORD) ctrl.Halt    = 1'b1;
        else                    ctrl.illegal = 1'b1;
      end
      default: ctrl.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/decode_queue_unit.sv
// Instruction queue between fetch and execute; decodes the head entry.
module decode_queue_unit
  import cpu_types_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int WORD_W = 32
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     flush,
  input  logic                     instr_valid,
  input  logic [WORD_W-1:0]        instr,
  input  logic [WORD_W-1:0]        pc_in,
  output logic                     instr_ready,
  output logic                     ctrl_valid,
  input  logic                     ctrl_ready,
  output ctrl_t                    ctrl,
  output logic [WORD_W-1:0]        pc_out,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     halted
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef struct packed {
    logic [WORD_W-1:0] instr;
    logic [WORD_W-1:0] pc;
  } entry_t;

  entry_t          mem [DEPTH];
  logic [PW-1:0]   rptr, wptr;
  logic            doPush, doPop, popHalt;
  ctrl_t           headCtrl;
  word_t           decIn;

  assign decIn = word_t'(mem[rptr].instr);

  instr_decoder uDec (
    .instr (decIn),
    .ctrl  (headCtrl)
  );

  assign instr_ready = !RST && !halted && (count < FULL);
  assign ctrl_valid  = !RST && !halted && (count != '0);
  assign ctrl        = ctrl_valid ? headCtrl : CTRL_NOP;
  assign pc_out      = mem[rptr].pc;

  assign doPush  = instr_valid && instr_ready;
  assign doPop   = ctrl_valid && ctrl_ready;
  // Consuming a HALT wins even over flush, so halted is never lost to a redirect.
  assign popHalt = doPop && headCtrl.Halt;

  // Pointer/occupancy/halt state: reset, then halt, then flush, then normal push/pop.
  always_ff @(posedge CLK) begin
    if (RST) begin
      count  <= '0;
      rptr   <= '0;
      wptr   <= '0;
      halted <= 1'b0;
    end else if (popHalt) begin
      halted <= 1'b1;
      count  <= '0;
      rptr   <= wptr;
    end else if (flush) begin
      count <= '0;
      rptr  <= wptr;
    end else begin
      if (doPush) wptr <= wptr + 1'b1;
      if (doPop)  rptr <= rptr + 1'b1;
      case ({doPush, doPop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage; only written on an accepted push that is not cancelled.
  always_ff @(posedge CLK) begin
    if (doPush && !flush && !popHalt) mem[wptr] <= '{instr: instr, pc: pc_in};
  end

endmodule

// File: tb/tb_decode_queue_unit.sv
// Directed bench for decode_queue_unit.
module tb_decode_queue_unit;
  import cpu_types_pkg::*;

  logic        CLK = 1'b0;
  logic        RST, flush, instr_valid, ctrl_ready;
  logic [31:0] instr, pc_in, pc_out;
  logic        instr_ready, ctrl_valid, halted;
  ctrl_t       ctrl;
  logic [2:0]  count;

  int nChk = 0;
  int nErr = 0;
  ctrl_t e;

  decode_queue_unit #(.DEPTH(4), .WORD_W(32)) dut (
    .CLK(CLK), .RST(RST), .flush(flush), .instr_valid(instr_valid),
    .instr(instr), .pc_in(pc_in), .instr_ready(instr_ready),
    .ctrl_valid(ctrl_valid), .ctrl_ready(ctrl_ready), .ctrl(ctrl),
    .pc_out(pc_out), .count(count), .halted(halted)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nChk++;
    if (got !== exp) begin
      nErr++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic push(input logic [31:0] w, input logic [31:0] p);
    instr_valid = 1'b1; instr = w; pc_in = p;
    step();
    instr_valid = 1'b0;
  endtask

  initial begin
    RST = 1'b1; flush = 1'b0; instr_valid = 1'b0; ctrl_ready = 1'b0;
    instr = '0; pc_in = '0;
    step(); step();
    chk("rst_cvalid", ctrl_valid, 0);
    chk("rst_iready", instr_ready, 0);
    chk("rst_count", count, 0);
    chk("rst_halted", halted, 0);
    RST = 1'b0;
    #1;
    chk("iready_after_rst", instr_ready, 1);
    chk("ctrl_zero_empty", ctrl, 0);

    // 1: ADDU visible one cycle after push
    push(32'h00221821, 32'h0);
    chk("t1_cvalid", ctrl_valid, 1);
    chk("t1_regdst", ctrl.RegDst, 1);
    chk("t1_regwrite", ctrl.RegWrite, 1);
    chk("t1_aluop", ctrl.ALUOp, ALU_ADD);
    e = CTRL_NOP; e.RegDst = 1; e.RegWrite = 1; e.ALUOp = ALU_ADD;
    chk("t1_ctrl", ctrl, e);
    chk("t1_pc", pc_out, 32'h0);
    chk("t1_count", count, 1);
    ctrl_ready = 1'b1; step(); ctrl_ready = 1'b0;
    chk("t1_drain", count, 0);

    // 2: fill, overflow attempt, pop+push across wrap
    push(32'h00221821, 32'h10);
    push(32'h00221821, 32'h14);
    push(32'h00221821, 32'h18);
    push(32'h00221821, 32'h1C);
    chk("t2_full_count", count, 4);
    chk("t2_full_iready", instr_ready, 0);
    push(32'h00221821, 32'h20);
    chk("t2_5th_ignored", count, 4);
    chk("t2_head0", pc_out, 32'h10);
    ctrl_ready = 1'b1; step();
    chk("t2_pop_count", count, 3);
    chk("t2_head1", pc_out, 32'h14);
    push(32'h00221821, 32'h24);
    chk("t2_pp_count", count, 3);
    chk("t2_head2", pc_out, 32'h18);
    ctrl_ready = 1'b0;
    // Drain while checking order: 0x18, 0x1C, 0x24
    ctrl_ready = 1'b1;
    step(); chk("t2_head3", pc_out, 32'h1C);
    step(); chk("t2_head4", pc_out, 32'h24);
    step(); chk("t2_empty", count, 0);
    chk("t2_cvalid", ctrl_valid, 0);
    ctrl_ready = 1'b0;

    // 3: LW, LL, SC decode
    push(32'h8C220004, 32'h40);
    push(32'hC0220000, 32'h44);
    push(32'hE0220000, 32'h48);
    e = CTRL_NOP; e.MemRead = 1; e.MemToReg = 1; e.ALUSrc = 1; e.SignExtend = 1;
    e.RegWrite = 1; e.ALUOp = ALU_ADD;
    chk("t3_lw_ctrl", ctrl, e);
    chk("t3_lw_datomic", ctrl.datomic, 0);
    ctrl_ready = 1'b1; step(); ctrl_ready = 1'b0;
    chk("t3_ll_memread", ctrl.MemRead, 1);
    chk("t3_ll_datomic", ctrl.datomic, 1);
    chk("t3_ll_pc", pc_out, 32'h44);
    ctrl_ready = 1'b1; step(); ctrl_ready = 1'b0;
    e = CTRL_NOP; e.MemWrite = 1; e.RegWrite = 1; e.MemToReg = 1; e.datomic = 1;
    e.ALUSrc = 1; e.SignExtend = 1; e.ALUOp = ALU_ADD;
    chk("t3_sc_ctrl", ctrl, e);

    // 4: flush with a concurrent push at count=3
    push(32'h00221821, 32'h4C);
    push(32'h00221821, 32'h50);
    chk("t4_pre_count", count, 3);
    flush = 1'b1;
    push(32'h00221821, 32'h54);
    flush = 1'b0;
    chk("t4_count", count, 0);
    chk("t4_cvalid", ctrl_valid, 0);
    push(32'h00221821, 32'h60);
    chk("t4_not_stored", pc_out, 32'h60);
    chk("t4_count1", count, 1);
    ctrl_ready = 1'b1; step(); ctrl_ready = 1'b0;

    // 5: HALT then ADDU, pop HALT
    push(32'hFFFFFFFF, 32'h70);
    push(32'h00221821, 32'h74);
    e = CTRL_NOP; e.Halt = 1;
    chk("t5_halt_ctrl", ctrl, e);
    ctrl_ready = 1'b1; step(); ctrl_ready = 1'b0;
    chk("t5_halted", halted, 1);
    chk("t5_cvalid", ctrl_valid, 0);
    chk("t5_iready", instr_ready, 0);
    chk("t5_count", count, 0);
    push(32'h00221821, 32'h78);
    chk("t5_push_ignored", count, 0);
    chk("t5_still_halted", halted, 1);
    RST = 1'b1; step(); RST = 1'b0;
    #1;
    chk("t5_rst_clear", halted, 0);
    chk("t5_rst_iready", instr_ready, 1);

    // 6: opcode 0x3F that is not the HALT word
    push(32'hFC000000, 32'h80);
    e = CTRL_NOP; e.illegal = 1;
    chk("t6_illegal_ctrl", ctrl, e);
    chk("t6_cvalid", ctrl_valid, 1);
    ctrl_ready = 1'b1; step(); ctrl_ready = 1'b0;
    chk("t6_popped", count, 0);
    chk("t6_not_halted", halted, 0);

    $display("CHECKS %0d ERRORS %0d", nChk, nErr);
    $finish;
  end

endmodule
